// File: rtl/partial_capture_fifo.sv
// -----------------------------------------------------------------------------
// partial_capture_fifo
//
// Captures output words of an upstream extracted partial circuit into a small
// FIFO so a consumer can drain them at its own pace. A word pushed on one CLK
// edge is visible at the head right after that edge; there is no same-cycle
// bypass when empty. Words arriving while the FIFO is full with no pop in the
// same cycle are dropped, and this sets the sticky overflow flag.
//
// Optional feature (compile-time macro):
//   PARTIAL_CAPTURE_PARITY_EN -- each entry also stores the even parity of the
//   captured word, and the stored parity of the head entry appears on O_parity.
//
// Parameters:
//   WIDTH  bits per captured word
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   ASYNCRESET  asynchronous active-high reset
//   I           word from the upstream circuit
//   I_valid     capture I this cycle
//   clear       synchronous flush (pointers, count, overflow)
//   O           head-of-FIFO word, 0 while empty
//   O_valid     head holds a captured word (count != 0)
//   O_ready     consumer accepts O this cycle
//   count       occupied entries, 0..DEPTH
//   full        count == DEPTH
//   O_parity    stored parity of the head entry, 0 while empty (macro only)
//   overflow    sticky: a word was dropped since the last clear/reset
// -----------------------------------------------------------------------------
module partial_capture_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic [WIDTH-1:0]         I,
    input  logic                     I_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         O,
    output logic                     O_valid,
    input  logic                     O_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef PARTIAL_CAPTURE_PARITY_EN
    output logic                     O_parity,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef PARTIAL_CAPTURE_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          drop;

    // Handshake. A pop frees a slot in the same cycle, so a full FIFO can
    // still accept a word when the consumer is draining.
    assign full    = (count == CW'(DEPTH));
    assign O_valid = (count != '0);
    assign pop     = O_valid && O_ready;
    assign push    = I_valid && (!full || pop);
    assign drop    = I_valid && full && !pop;

`ifdef PARTIAL_CAPTURE_PARITY_EN
    // Even parity: the stored bit makes the total number of ones even.
    assign wr_word = {^I, I};
`else
    assign wr_word = I;
`endif

    // Storage is never reset; the head is masked with O_valid instead so the
    // outputs read 0 whenever the FIFO is empty, including during reset.
    always_ff @(posedge CLK) begin
        if (push && !clear)
            mem[wr_ptr] <= wr_word;
    end

    assign head = mem[rd_ptr];
    assign O    = O_valid ? head[WIDTH-1:0] : '0;

`ifdef PARTIAL_CAPTURE_PARITY_EN
    assign O_parity = O_valid ? head[WIDTH] : 1'b0;
`endif

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Flush wins over any push, pop or overflow event this cycle.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/partial_capture_fifo.md
PARTIAL_CAPTURE_FIFO -- requirements
Module: partial_capture_fifo

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 5, bit width of one captured output word (O4..O0 of the extracted partial circuit, O0 at bit 0).
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

REQ-002 Ports SHALL be:
- CLK  input  1  single clock; all state updates on its rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I  input  WIDTH  output word of the upstream extracted circuit.
- I_valid  input  1  I is to be captured this cycle.
- clear  input  1  synchronous flush.
- O  output  WIDTH  head-of-FIFO word.
- O_valid  output  1  O holds a captured word.
- O_ready  input  1  consumer accepts O this cycle.
- count  output  log2(DEPTH)+1  number of occupied entries.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag, set when a word is dropped.

Function
REQ-003 push SHALL be I_valid && (!full || pop); pop SHALL be O_valid && O_ready.
REQ-004 A pushed word SHALL be written at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-005 A pop SHALL increment the read pointer modulo DEPTH.
REQ-006 O SHALL be the entry at the read pointer, driven combinationally from storage; O_valid SHALL equal (count != 0).
REQ-007 Capture latency SHALL be 1 cycle: a word pushed at edge N SHALL be visible on O/O_valid after edge N; there SHALL be no same-cycle bypass when empty.
REQ-008 Simultaneous push and pop SHALL leave count unchanged.
REQ-009 When full, push is accepted only with a simultaneous pop.
REQ-010 I_valid with full and no pop SHALL drop the word, leave storage and pointers unchanged, and set overflow.
REQ-011 overflow SHALL remain set until clear or ASYNCRESET.
REQ-012 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-013 O_ready while empty SHALL have no effect.
REQ-014 clear SHALL zero both pointers, count and overflow, and SHALL take priority over push, pop and overflow set in the same cycle.
REQ-015 Storage contents after clear or reset SHALL be don't-care, but O SHALL read 0 while O_valid is 0.

Reset
REQ-016 Asserting ASYNCRESET SHALL immediately, without waiting for CLK, force pointers = 0, count = 0, full = 0, overflow = 0, O_valid = 0 and O = 0, including mid-transfer.
REQ-017 The first push SHALL be accepted at the first rising CLK edge after ASYNCRESET deasserts.

Configuration
REQ-018 With PARTIAL_CAPTURE_PARITY_EN defined:
- Each entry SHALL store WIDTH+1 bits, with even parity of I computed at push.
- An extra output port O_parity (1 bit) SHALL present the stored parity of the head entry, and SHALL be 0 when empty or in reset.
REQ-019 Without PARTIAL_CAPTURE_PARITY_EN, O_parity and the parity storage SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-020 Reset then push 5'h01,5'h02,5'h03 with O_ready=0 -> count=3, O=5'h01, O_valid=1, full=0.
REQ-021 From empty, fill DEPTH=4 words 5'h11..5'h14, then I_valid with 5'h1F and O_ready=0 -> full=1, overflow=1, 5'h1F dropped; then drain -> 5'h11..5'h14 in order, count returns to 0.
REQ-022 With full, push 5'h0A and pop in the same cycle -> count stays 4; 5'h0A emerges after the 3 remaining older words; pointers wrap correctly across 2 full laps.
REQ-023 Assert clear together with I_valid and O_ready while count=2 and overflow=1 -> next cycle count=0, O_valid=0, overflow=0, nothing stored.
REQ-024 Assert ASYNCRESET between CLK edges with count=3 -> O_valid, count and overflow go to 0 before the next edge.
REQ-025 With PARTIAL_CAPTURE_PARITY_EN defined, push 5'h07 then 5'h03 -> O_parity=1 then 0 at the head.
